// File: rtl/ifetch_pkg.sv
// Shared state encoding, widths and helpers for the instruction fetch unit.
package ifetch_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam int                 INSTR_W = 32;
    localparam logic [31:0]        PC_INC  = 32'd4;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

    function automatic logic [31:0] pc_align(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding {pc, instr} pairs between fetch and decode.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues to instruction memory, buffers words for decode.
// Optional stall_cycles counter/port enabled by defining IFETCH_STALL_CNT_EN.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [31:0]        dec_pc
`ifdef IFETCH_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int             FW      = 32 + INSTR_W;
    localparam logic [CW:0]    DEPTH_V = FIFO_DEPTH[CW:0];

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        fetch_pc;
    logic [31:0]        pending_pc;
    logic               pending;
    logic [CW-1:0]      count;
    logic [CW:0]        occ;
    logic [FW-1:0]      head;
    logic               in_run;
    logic               resp;
    logic               space_ok;
    logic               req_fire;
    logic               push;
    logic               pop;

    // An in-flight fetch already owns a FIFO slot, so it counts as occupancy.
    assign occ      = {1'b0, count} + {{CW{1'b0}}, pending};
    assign in_run   = (state == S_RUN);
    assign resp     = pending & ~imem_stall;
    assign space_ok = (occ < DEPTH_V);
    assign req_fire = in_run & ~redirect_valid & ~imem_stall & space_ok;
    assign push     = in_run & resp & ~redirect_valid;
    assign pop      = dec_valid & dec_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_RUN;
            S_RUN: begin
                if (redirect_valid && pending && imem_stall) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (!redirect_valid && (!imem_stall || !pending)) state_nxt = S_RUN;
            end
            default: state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_RESET;
            fetch_pc <= RESET_PC;
            pending  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (redirect_valid)  fetch_pc <= pc_align(redirect_pc);
            else if (req_fire)   fetch_pc <= fetch_pc + PC_INC;
            // A returning word clears pending whether it is kept, discarded or stale.
            if (req_fire)        pending <= 1'b1;
            else if (resp)       pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) pending_pc <= fetch_pc;
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({pending_pc, imem_rdata}),
        .rdata (head),
        .count (count)
    );

    assign imem_addr = fetch_pc;
    assign dec_valid = (count != '0);
    assign dec_instr = dec_valid ? head[INSTR_W-1:0]  : '0;
    assign dec_pc    = dec_valid ? head[FW-1:INSTR_W] : '0;

`ifdef IFETCH_STALL_CNT_EN
    logic        stall_hit;
    logic [31:0] stall_cnt;

    assign stall_hit = (state == S_RUN || state == S_FLUSH) && imem_stall &&
                       (pending || (in_run && space_ok));

    always_ff @(posedge clk) begin
        if (!rst_n)                               stall_cnt <= '0;
        else if (stall_hit && stall_cnt != '1)    stall_cnt <= stall_cnt + 32'd1;
    end

    assign stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a registered instruction memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
`ifdef IFETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int n_pop = 0;
    logic [31:0] exp_q [$];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_stall     (imem_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
`ifdef IFETCH_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Memory: accepts an address when not stalled, word appears next cycle, held while stalled.
    always @(posedge clk) begin
        if (!imem_stall) imem_rdata <= imem_addr | 32'h0000_00A0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected stream after a reset or redirect to pc: pc, pc+4, pc+8, ...
    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready) begin
            logic [31:0] e;
            n_pop++;
            check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dec_pc", dec_pc, e);
                check("dec_instr", dec_instr, e | 32'h0000_00A0);
            end
        end else if (rst_n && !dec_valid) begin
            check("idle_pc_zero", dec_pc, 32'h0);
            check("idle_instr_zero", dec_instr, 32'h0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        logic [31:0] a0;
`ifdef IFETCH_STALL_CNT_EN
        logic [31:0] sc0;
`endif
        rst_n = 1'b0; imem_stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; dec_ready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_dec_pc", dec_pc, 32'h0);
        check("rst_dec_instr", dec_instr, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
`ifdef IFETCH_STALL_CNT_EN
        check("rst_stall_cycles", stall_cycles, 32'h0);
`endif

        // 1: release reset, stream one instruction per cycle
        restart(32'h0); dec_ready = 1'b1; rst_n = 1'b1;
        tick();
        check("t1_addr_c1", imem_addr, 32'h0);
        check("t1_valid_c1", 32'(dec_valid), 32'd0);
        tick();
        check("t1_addr_c2", imem_addr, 32'h4);
        check("t1_valid_c2", 32'(dec_valid), 32'd0);
        tick();
        check("t1_valid_c3", 32'(dec_valid), 32'd1);
        check("t1_first_pc", dec_pc, 32'h0);
        n0 = n_pop;
        repeat (8) tick();
        check("t1_throughput", 32'(n_pop - n0), 32'd8);

        // 2: decode back-pressure fills FIFO and stops issue at 0x10
        rst_n = 1'b0; dec_ready = 1'b0;
        tick();
        rst_n = 1'b1; restart(32'h0);
        repeat (10) tick();
        check("t2_addr_stop", imem_addr, 32'h10);
        check("t2_valid", 32'(dec_valid), 32'd1);
        check("t2_head_pc", dec_pc, 32'h0);
        tick();
        check("t2_addr_hold", imem_addr, 32'h10);
        n0 = n_pop;
        dec_ready = 1'b1;
        repeat (8) tick();
        check("t2_drain", 32'(n_pop - n0), 32'd8);

        // 3: three stall cycles mid-stream
        imem_stall = 1'b1; a0 = imem_addr;
`ifdef IFETCH_STALL_CNT_EN
        sc0 = stall_cycles;
`endif
        repeat (3) tick();
        check("t3_addr_stable", imem_addr, a0);
        check("t3_no_push", 32'(dec_valid), 32'd0);
`ifdef IFETCH_STALL_CNT_EN
        check("t3_stall_cycles", stall_cycles - sc0, 32'd3);
`endif
        imem_stall = 1'b0;
        repeat (6) tick();

        // 4: redirect while fetch pending and memory stalled
        imem_stall = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0; restart(32'h100);
        check("t4_valid_after", 32'(dec_valid), 32'd0);
        check("t4_addr", imem_addr, 32'h100);
        tick();
        imem_stall = 1'b0;
        n0 = n_pop;
        repeat (8) tick();
        check("t4_resumed", 32'(n_pop > n0), 32'd1);

        // 5: redirect coinciding with a pop at full FIFO
        dec_ready = 1'b0;
        repeat (8) tick();
        check("t5_full_valid", 32'(dec_valid), 32'd1);
        n0 = n_pop;
        dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0; dec_ready = 1'b0; restart(32'h200);
        check("t5_one_pop", 32'(n_pop - n0), 32'd1);
        check("t5_empty", 32'(dec_valid), 32'd0);
        check("t5_addr", imem_addr, 32'h200);
        dec_ready = 1'b1;
        n0 = n_pop;
        repeat (8) tick();
        check("t5_resumed", 32'(n_pop > n0), 32'd1);

        // 6: reset mid-stream with a fetch in flight
        rst_n = 1'b0;
        tick();
        check("t6_valid", 32'(dec_valid), 32'd0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_pc", dec_pc, 32'h0);
`ifdef IFETCH_STALL_CNT_EN
        check("t6_stall_cycles", stall_cycles, 32'h0);
`endif
        rst_n = 1'b1; restart(32'h0);
        n0 = n_pop;
        repeat (8) tick();
        check("t6_resumed", 32'(n_pop > n0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
